// File: rtl/ad9226_udp_pkg.sv
// Shared types and helpers for the AD9226 -> W5500 UDP packer.
package ad9226_udp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    FETCH,
    PUSH,
    ACK_LO,
    ACK_HI,
    FLUSH,
    FL_LO,
    FL_HI
  } state_t;

  localparam int          WORD_W            = 48;
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5A5;

  // Header layout: sync pattern, packet sequence number, payload length in words.
  function automatic logic [WORD_W-1:0] build_header(input logic [15:0] sync,
                                                     input logic [15:0] seq,
                                                     input logic [15:0] len);
    return {sync, seq, len};
  endfunction

endpackage

// File: rtl/ad9226_udp_packer_if.sv
// Word/flush handshake between the packer (master) and the W5500 UDP engine (slave).
interface ad9226_udp_packer_if;
  logic        wiz_available;
  logic        data_input_valid;
  logic [47:0] data_input;
  logic        flush_requested;

  modport master (
    input  wiz_available,
    output data_input_valid,
    output data_input,
    output flush_requested
  );

  modport slave (
    output wiz_available,
    input  data_input_valid,
    input  data_input,
    input  flush_requested
  );
endinterface

// File: rtl/ad9226_sample_gather.sv
// Pops samples one at a time from the sample FIFO and packs four of them into a word.
module ad9226_sample_gather #(
  parameter int SAMPLE_W        = 12,
  parameter int FIFO_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [SAMPLE_W-1:0]   fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  output logic                  done,
  output logic [4*SAMPLE_W-1:0] word
);

  logic [FIFO_RD_LATENCY-1:0] pend;
  logic [1:0]                 slot;
  logic [3*SAMPLE_W-1:0]      held;
  logic                       capture;

  // One read in flight at a time keeps ordering trivial across underruns.
  assign capture    = pend[FIFO_RD_LATENCY-1];
  assign fifo_rdreq = run && !fifo_empty && (pend == '0);
  assign done       = capture && (slot == 2'd3);
  assign word       = {held, fifo_q};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere in clocked logic so every flop sees pre-edge values.
    if (rst) begin
      pend <= '0;
      slot <= '0;
    end else begin
      pend[0] <= fifo_rdreq;
      for (int i = 1; i < FIFO_RD_LATENCY; i++) begin
        pend[i] <= pend[i-1];
      end
      if (capture) begin
        slot <= slot + 2'd1;
      end
    end
  end

  // NOTE: held is pure datapath and is not reset; restarting slot at 0 discards its contents.
  always_ff @(posedge clk) begin
    if (capture) begin
      held <= {held[2*SAMPLE_W-1:0], fifo_q};
    end
  end

endmodule

// File: rtl/ad9226_udp_packer.sv
// Packet framer: header word, WORDS_PER_PACKET packed sample words, then a flush request.
module ad9226_udp_packer
  import ad9226_udp_pkg::*;
#(
  parameter int          SAMPLE_W         = 12,
  parameter int          WORDS_PER_PACKET = 245,
  parameter logic [15:0] SYNC_WORD        = SYNC_WORD_DEFAULT,
  parameter int          FIFO_RD_LATENCY  = 1,
  parameter logic [15:0] SEQ_INIT         = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [SAMPLE_W-1:0]        fifo_q,
  input  logic                       fifo_empty,
  output logic                       fifo_rdreq,
  ad9226_udp_packer_if.master        wiz,
  output logic                       packet_done,
  output logic [15:0]                seq_num,
  output logic                       busy
);

  localparam logic [9:0]  WPP_CNT = 10'(WORDS_PER_PACKET);
  localparam logic [15:0] WPP_HDR = 16'(WORDS_PER_PACKET);

  state_t              state, state_next;
  logic [9:0]          word_cnt;
  logic                is_hdr;
  logic [WORD_W-1:0]   data_word;
  logic                word_valid;
  logic                flush_req;
  logic                gather_done;
  logic [WORD_W-1:0]   gather_word;

  ad9226_sample_gather #(
    .SAMPLE_W        (SAMPLE_W),
    .FIFO_RD_LATENCY (FIFO_RD_LATENCY)
  ) u_gather (
    .clk        (clk),
    .rst        (rst),
    .run        (state == FETCH),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .done       (gather_done),
    .word       (gather_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Strobes are Mealy on wiz_available so a word goes out the cycle the engine frees up.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next  = state;
    word_valid  = 1'b0;
    flush_req   = 1'b0;
    packet_done = 1'b0;
    case (state)
      IDLE:   if (enable) state_next = HDR;
      HDR:    state_next = PUSH;
      FETCH:  if (gather_done) state_next = PUSH;
      PUSH: begin
        if (wiz.wiz_available) begin
          word_valid = 1'b1;
          state_next = ACK_LO;
        end
      end
      ACK_LO: if (!wiz.wiz_available) state_next = ACK_HI;
      ACK_HI: begin
        if (wiz.wiz_available) begin
          if (!is_hdr && (word_cnt + 10'd1 == WPP_CNT)) state_next = FLUSH;
          else                                          state_next = FETCH;
        end
      end
      FLUSH: begin
        if (wiz.wiz_available) begin
          flush_req  = 1'b1;
          state_next = FL_LO;
        end
      end
      FL_LO:  if (!wiz.wiz_available) state_next = FL_HI;
      FL_HI: begin
        if (wiz.wiz_available) begin
          packet_done = 1'b1;
          state_next  = enable ? HDR : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_word <= '0;
      is_hdr    <= 1'b0;
      word_cnt  <= '0;
      seq_num   <= SEQ_INIT;
    end else begin
      if (state == HDR) begin
        data_word <= build_header(SYNC_WORD, seq_num, WPP_HDR);
        is_hdr    <= 1'b1;
      end
      if (state == FETCH && gather_done) begin
        data_word <= gather_word;
        is_hdr    <= 1'b0;
      end
      if (state == ACK_HI && wiz.wiz_available && !is_hdr) begin
        word_cnt <= word_cnt + 10'd1;
      end
      if (state == FL_HI && wiz.wiz_available) begin
        seq_num  <= seq_num + 16'd1;
        word_cnt <= '0;
      end
    end
  end

  assign wiz.data_input       = data_word;
  assign wiz.data_input_valid = word_valid;
  assign wiz.flush_requested  = flush_req;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_ad9226_udp_packer.sv
// Directed bench for ad9226_udp_packer with a FIFO model and a slow-accepting engine model.
module tb_ad9226_udp_packer;

  localparam int WPP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] fifo_q = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rdreq, packet_done, busy;
  logic [15:0] seq_num;
  logic        fifo_rdreq_w, packet_done_w, busy_w;
  logic [15:0] seq_num_w;

  ad9226_udp_packer_if wiz ();
  ad9226_udp_packer_if wiz_w ();
  assign wiz_w.wiz_available = wiz.wiz_available;

  always #5 clk = ~clk;

  ad9226_udp_packer #(.WORDS_PER_PACKET(WPP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .wiz(wiz), .packet_done(packet_done), .seq_num(seq_num), .busy(busy)
  );

  // Lockstep twin whose sequence counter starts at 16'hFFFF to exercise the wrap.
  ad9226_udp_packer #(.WORDS_PER_PACKET(WPP), .SEQ_INIT(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq_w), .wiz(wiz_w), .packet_done(packet_done_w), .seq_num(seq_num_w),
    .busy(busy_w)
  );

  logic [11:0] mem [64];
  int          wr_cnt = 0, rd_ptr = 0, cyc = 0, busy_cnt = 0;
  bit          stall = 0, hold = 0;
  logic [47:0] words[$], words_w[$];
  int          flush_cnt = 0, done_cnt = 0;
  int          viol_both = 0, viol_unavail = 0, viol_empty = 0, viol_lockstep = 0;
  int          tests_run = 0, tests_failed = 0;

  // FIFO (read latency 1) and engine model: observe on negedge, update inputs 1 after posedge.
  initial begin
    bit pop, strobe;
    wiz.wiz_available = 1'b1;
    forever begin
      @(negedge clk);
      pop    = fifo_rdreq && !fifo_empty;
      strobe = wiz.data_input_valid || wiz.flush_requested;
      if (wiz.data_input_valid) begin
        words.push_back(wiz.data_input);
        words_w.push_back(wiz_w.data_input);
      end
      if (wiz.flush_requested) flush_cnt++;
      if (packet_done) done_cnt++;
      if (wiz.data_input_valid && wiz.flush_requested) viol_both++;
      if (strobe && !wiz.wiz_available) viol_unavail++;
      if (fifo_rdreq && fifo_empty) viol_empty++;
      if (fifo_rdreq_w !== fifo_rdreq || busy_w !== busy || packet_done_w !== packet_done)
        viol_lockstep++;
      @(posedge clk);
      #1;
      cyc++;
      if (pop) begin
        fifo_q = mem[rd_ptr];
        rd_ptr++;
      end
      fifo_empty = (rd_ptr >= wr_cnt) || (stall && ((cyc / 3) % 2 == 1));
      if (strobe) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      wiz.wiz_available = (busy_cnt == 0) && !hold;
    end
  end

  function automatic logic [47:0] pick(input int i);
    if (i < words.size()) return words[i];
    return 'x;
  endfunction

  function automatic logic [47:0] pick_w(input int i);
    if (i < words_w.size()) return words_w[i];
    return 'x;
  endfunction

  task automatic load_fifo(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) mem[i] = base + 12'(i);
    rd_ptr = 0;
    wr_cnt = n;
  endtask

  task automatic clear_log();
    words.delete();
    words_w.delete();
    flush_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; hold = 0; stall = 0; busy_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic pulse_enable();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (done_cnt < target) begin
      tests_failed++;
      $display("FAIL %s: packet_done count %0d after timeout, expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_words(input int target, input string name);
    int n = 0;
    while (words.size() < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (words.size() < target) begin
      tests_failed++;
      $display("FAIL %s: %0d words after timeout, expected %0d", name, words.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({fifo_rdreq, wiz.data_input_valid, wiz.flush_requested, packet_done, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, expected 00000", {fifo_rdreq, wiz.data_input_valid,
               wiz.flush_requested, packet_done, busy});
    end
    tests_run++;
    if (seq_num !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_seq: got %h, expected 0000", seq_num);
    end
    tests_run++;
    if (wiz.data_input !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, expected 000000000000", wiz.data_input);
    end
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_basic_enable_drop();
    logic [47:0] exp_w [3];
    exp_w = '{48'hA5A5_0000_0002, 48'h001002003004, 48'h005006007008};
    load_fifo(12'h001, 8);
    clear_log();
    @(negedge clk);
    enable = 1'b1;
    wait_words(1, "basic_hdr_wait");
    enable = 1'b0;
    wait_done(1, "basic_done_wait");
    repeat (30) @(negedge clk);
    tests_run++;
    if (words.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d words, expected 3", words.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pick(i) !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL basic_word%0d: got %h, expected %h", i, pick(i), exp_w[i]);
      end
    end
    tests_run++;
    if (flush_cnt != 1 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL basic_flush: flush %0d done %0d, expected 1 and 1", flush_cnt, done_cnt);
    end
    tests_run++;
    if (seq_num !== 16'h0001) begin
      tests_failed++;
      $display("FAIL basic_seq: got %h, expected 0001", seq_num);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: busy %b, expected 0", busy);
    end
  endtask

  task automatic test_rst_mid_fetch();
    logic [47:0] exp_w [3];
    int n = 0;
    exp_w = '{48'hA5A5_0000_0002, 48'h103104105106, 48'h10710810910A};
    load_fifo(12'h101, 16);
    clear_log();
    pulse_enable();
    while (rd_ptr < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (rd_ptr < 2) begin
      tests_failed++;
      $display("FAIL rst_fetch_wait: %0d pops after timeout, expected 2", rd_ptr);
    end
    tests_run++;
    if (wiz.data_input !== 48'hA5A5_0001_0002 || seq_num !== 16'h0001) begin
      tests_failed++;
      $display("FAIL rst_pre: data %h seq %h, expected a5a500010002 and 0001", wiz.data_input, seq_num);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({fifo_rdreq, wiz.data_input_valid, wiz.flush_requested, packet_done, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_ctrl: got %b, expected 00000", {fifo_rdreq, wiz.data_input_valid,
               wiz.flush_requested, packet_done, busy});
    end
    tests_run++;
    if (wiz.data_input !== 48'h0 || seq_num !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_data: data %h seq %h, expected zeros", wiz.data_input, seq_num);
    end
    rst = 1'b0;
    clear_log();
    pulse_enable();
    wait_done(1, "rst_restart_wait");
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pick(i) !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL rst_word%0d: got %h, expected %h", i, pick(i), exp_w[i]);
      end
    end
  endtask

  task automatic test_underrun_stall();
    logic [47:0] exp_w [3];
    exp_w = '{48'hA5A5_0000_0002, 48'h001002003004, 48'h005006007008};
    do_reset();
    load_fifo(12'h001, 8);
    stall = 1;
    pulse_enable();
    wait_done(1, "stall_done_wait");
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pick(i) !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL stall_word%0d: got %h, expected %h", i, pick(i), exp_w[i]);
      end
    end
    tests_run++;
    if (rd_ptr != 8 || viol_empty != 0) begin
      tests_failed++;
      $display("FAIL stall_pops: pops %0d rdreq-while-empty %0d, expected 8 and 0", rd_ptr, viol_empty);
    end
    stall = 0;
  endtask

  task automatic test_wiz_hold();
    int strobes = 0;
    do_reset();
    load_fifo(12'h001, 8);
    hold = 1;
    repeat (2) @(negedge clk);
    pulse_enable();
    repeat (500) begin
      @(negedge clk);
      if (wiz.data_input_valid || wiz.flush_requested) strobes++;
    end
    tests_run++;
    if (strobes != 0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_quiet: strobes %0d busy %b, expected 0 and 1", strobes, busy);
    end
    hold = 0;
    @(negedge clk);
    tests_run++;
    if (wiz.data_input_valid !== 1'b1 || wiz.data_input !== 48'hA5A5_0000_0002) begin
      tests_failed++;
      $display("FAIL hold_release: valid %b data %h, expected 1 and a5a500000002",
               wiz.data_input_valid, wiz.data_input);
    end
    wait_done(1, "hold_done_wait");
    tests_run++;
    if (words.size() != 3 || pick(2) !== 48'h005006007008) begin
      tests_failed++;
      $display("FAIL hold_stream: %0d words last %h, expected 3 and 005006007008", words.size(), pick(2));
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    tests_run++;
    if (seq_num_w !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_init: got %h, expected ffff", seq_num_w);
    end
    load_fifo(12'h001, 16);
    @(negedge clk);
    enable = 1'b1;
    wait_done(1, "wrap_first_wait");
    wait_words(4, "wrap_hdr2_wait");
    enable = 1'b0;
    wait_done(2, "wrap_second_wait");
    repeat (5) @(negedge clk);
    tests_run++;
    if (pick_w(0) !== 48'hA5A5_FFFF_0002) begin
      tests_failed++;
      $display("FAIL wrap_hdr0: got %h, expected a5a5ffff0002", pick_w(0));
    end
    tests_run++;
    if (pick_w(3) !== 48'hA5A5_0000_0002) begin
      tests_failed++;
      $display("FAIL wrap_hdr1: got %h, expected a5a500000002", pick_w(3));
    end
    tests_run++;
    if (pick(3) !== 48'hA5A5_0001_0002 || pick(4) !== 48'h00900A00B00C) begin
      tests_failed++;
      $display("FAIL wrap_main: hdr %h word %h, expected a5a500010002 and 00900a00b00c", pick(3), pick(4));
    end
    tests_run++;
    if (seq_num_w !== 16'h0001 || seq_num !== 16'h0002) begin
      tests_failed++;
      $display("FAIL wrap_seq: twin %h main %h, expected 0001 and 0002", seq_num_w, seq_num);
    end
  endtask

  task automatic test_protocol();
    tests_run++;
    if (viol_both != 0 || viol_unavail != 0) begin
      tests_failed++;
      $display("FAIL protocol: overlapping strobes %0d, strobes while unavailable %0d, expected 0 and 0",
               viol_both, viol_unavail);
    end
    tests_run++;
    if (viol_lockstep != 0 || viol_empty != 0) begin
      tests_failed++;
      $display("FAIL lockstep: divergences %0d, rdreq-while-empty %0d, expected 0 and 0",
               viol_lockstep, viol_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic_enable_drop();
    test_rst_mid_fetch();
    test_underrun_stall();
    test_wiz_hold();
    test_seq_wrap();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ad9226_udp_packer.md
Name: ad9226_udp_packer

Overview:
- Upstream feeder for the W5500 UDP streaming engine.
- Pops 12-bit AD9226 samples from the sample FIFO and packs 4 samples into each 48-bit TX word.
- Prepends one header word per packet and pushes the words through the engine's valid/available handshake.
- After WORDS_PER_PACKET payload words it requests a flush (UDP send), bumps the sequence number and starts the next packet.

Parameters:
- SAMPLE_W, 12, ADC sample width; fixed at 12 so that 4 samples fill 48 bits.
- WORDS_PER_PACKET, 245, payload words per packet (excluding header), legal range 1..1023.
- SYNC_WORD, 16'hA5A5, header sync pattern.
- FIFO_RD_LATENCY, 1, cycles from fifo_rdreq to valid fifo_q (legal 1 or 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 0 stops the block at the next packet boundary.
- fifo_q  in  12  sample FIFO read data.
- fifo_empty  in  1  sample FIFO empty.
- fifo_rdreq  out  1  one-cycle FIFO pop strobe.
- wiz_available  in  1  engine idle and able to accept.
- data_input_valid  out  1  one-cycle word strobe to the engine.
- data_input  out  48  TX word to the engine.
- flush_requested  out  1  one-cycle packet-send strobe to the engine.
- packet_done  out  1  one-cycle pulse when the flush has been accepted.
- seq_num  out  16  sequence number of the current or next packet.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, data_input 48'h0, seq_num 0, state IDLE, counters 0.
- Header word: {SYNC_WORD, seq_num, 16'(WORDS_PER_PACKET)}.
- Sample packing: the first popped sample goes to bits [47:36], then [35:24], [23:12], last to [11:0].
- State IDLE -> HDR when enable=1; otherwise stay in IDLE.
- HDR: load the header into data_input, then -> PUSH.
- FETCH: if fifo_empty=0, pulse fifo_rdreq for 1 cycle and wait FIFO_RD_LATENCY cycles. Capture fifo_q into the next slot. Repeat until 4 samples are held, then -> PUSH. If fifo_empty=1, hold with no rdreq.
- PUSH: wait until wiz_available=1, then assert data_input_valid for exactly 1 cycle, -> ACK_LO.
  - data_input stays stable from load until ACK_HI exits.
- ACK_LO: wait for wiz_available=0 (word accepted), -> ACK_HI.
- ACK_HI: wait for wiz_available=1, then:
  - If the word was the header -> FETCH.
  - Otherwise increment word_cnt. If word_cnt reaches WORDS_PER_PACKET -> FLUSH, else -> FETCH.
- FLUSH: wait until wiz_available=1, pulse flush_requested for 1 cycle, -> FL_LO.
- FL_LO: wait for wiz_available=0, -> FL_HI.
- FL_HI: wait for wiz_available=1, then:
  - pulse packet_done;
  - seq_num += 1, wrapping 16'hFFFF -> 0;
  - clear word_cnt;
  - if enable=1 -> HDR, else -> IDLE.
- data_input_valid and flush_requested are never high in the same cycle.
- No strobe is issued while wiz_available=0.
- enable dropping mid-packet: the packet completes, including its flush, before returning to IDLE. No partial packets are sent.
- FIFO underrun: stalls only; sample order is preserved and nothing is duplicated.
- rst mid-operation: immediate return to IDLE with seq_num=0. Partially packed samples are discarded.
- Samples held in the FIFO are not flushed by rst.
- word_cnt is 10 bits and compares for equality with WORDS_PER_PACKET.

Decomposition:
- Package ad9226_udp_pkg holds:
  - state enum (IDLE, HDR, FETCH, PUSH, ACK_LO, ACK_HI, FLUSH, FL_LO, FL_HI);
  - SYNC_WORD default;
  - the header-assembly function.
- One natural sub-module, ad9226_sample_gather: FIFO pop/latency pipeline plus 4-slot shift packer, with a done/start handshake to the FSM.

Test Plan:
- Full FIFO, WORDS_PER_PACKET=2, wiz model busy for 10 cycles per accept -> header 48'hA5A5_0000_0002, then 2 packed words, 1 flush_requested, packet_done, seq_num=1.
- FIFO holds samples 12'h001..12'h008 -> payload words 48'h001002003004 and 48'h005006007008, in order.
- fifo_empty toggled every 3 cycles -> identical word stream to the non-stalled run; fifo_rdreq never high while fifo_empty=1.
- wiz_available held 0 for 500 cycles at PUSH -> no strobe; data_input_valid fires within 1 cycle of wiz_available rising.
- enable dropped after the header -> the packet still completes with its flush, then IDLE with busy=0.
- seq_num preloaded at 16'hFFFF via packet sequencing -> next header carries 16'hFFFF, then 16'h0000; rst mid-FETCH -> all outputs 0 next cycle.
